// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with memory-wait timeout FSM (optional PIPE_FORWARDING_EN)
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_src1_vld,
  input  logic             id_src2_vld,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_branch,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             be_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_mem_timeout;

  logic              w_hz;
  logic              w_mem_stall;
  logic              w_if_freeze;
  logic              w_if_flush;
  logic              w_id_flush;
  logic              w_be_freeze;
  logic              w_unused_ok;

`ifdef PIPE_FORWARDING_EN
  // Forwarding covers everything except a load whose data is not back yet
  assign w_hz = exe_mem_r_en & exe_wb_en &
                ((id_src1_vld & (exe_dest == id_src1)) |
                 (id_src2_vld & (exe_dest == id_src2)));
  assign w_unused_ok = &{1'b0, mem_dest, mem_wb_en};
`else
  logic w_raw1;
  logic w_raw2;
  assign w_raw1 = id_src1_vld & ((exe_wb_en & (exe_dest == id_src1)) |
                                 (mem_wb_en & (mem_dest == id_src1)));
  assign w_raw2 = id_src2_vld & ((exe_wb_en & (exe_dest == id_src2)) |
                                 (mem_wb_en & (mem_dest == id_src2)));
  assign w_hz = w_raw1 | w_raw2;
  assign w_unused_ok = exe_mem_r_en;
`endif

  assign w_mem_stall = mem_req & ~mem_ready & (r_state != ST_ERR);

  // Prioritised control decode; held low while reset is asserted
  always_comb begin
    w_if_freeze = 1'b0;
    w_if_flush  = 1'b0;
    w_id_flush  = 1'b0;
    w_be_freeze = 1'b0;
    if (!rst) begin
      if (r_state == ST_ERR) begin
        w_if_freeze = 1'b1;
        w_be_freeze = 1'b1;
      end else if (w_mem_stall) begin
        w_if_freeze = 1'b1;
        w_be_freeze = 1'b1;
      end else if (exe_branch) begin
        w_if_flush = 1'b1;
        w_id_flush = 1'b1;
      end else if (w_hz) begin
        w_if_freeze = 1'b1;
        w_id_flush  = 1'b1;
      end
    end
  end

  // Memory-wait FSM with timeout counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wait_cnt <= '0;
          if (mem_req && !mem_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WC_W'(TIMEOUT - 1)) begin
            r_state       <= ST_ERR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        ST_ERR: r_state <= ST_ERR;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating count of fetch-freeze cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_if_freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign if_freeze   = w_if_freeze;
  assign if_flush    = w_if_flush;
  assign id_flush    = w_id_flush;
  assign be_freeze   = w_be_freeze;
  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_src1_vld, id_src2_vld, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic exe_branch, mem_req, mem_ready;

  logic d_if_freeze, d_if_flush, d_id_flush, d_be_freeze, d_mem_timeout;
  logic [15:0] d_stall_cnt;
  logic s_if_freeze, s_if_flush, s_id_flush, s_be_freeze, s_mem_timeout;
  logic [1:0] s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    bit         inst;
    logic [4:0] ctl;
    bit         chk_cnt;
    int         cnt;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_d (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_branch(exe_branch), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_freeze(d_if_freeze), .if_flush(d_if_flush), .id_flush(d_id_flush),
    .be_freeze(d_be_freeze), .mem_timeout(d_mem_timeout), .stall_cnt(d_stall_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) u_s (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_branch(exe_branch), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_freeze(s_if_freeze), .if_flush(s_if_flush), .id_flush(s_id_flush),
    .be_freeze(s_be_freeze), .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt)
  );

  // monitor: drain expectations at each falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      int acnt;
      e = q.pop_front();
      if (e.inst) begin
        act  = {s_if_freeze, s_if_flush, s_id_flush, s_be_freeze, s_mem_timeout};
        acnt = int'(s_stall_cnt);
      end else begin
        act  = {d_if_freeze, d_if_flush, d_id_flush, d_be_freeze, d_mem_timeout};
        acnt = int'(d_stall_cnt);
      end
      n_cmp++;
      if (act !== e.ctl) begin
        n_err++;
        $display("FAIL %s ctl{ifz,iff,idf,bez,tmo} got %b want %b", e.name, act, e.ctl);
      end
      if (e.chk_cnt) begin
        n_cmp++;
        if (acnt != e.cnt) begin
          n_err++;
          $display("FAIL %s stall_cnt got %0d want %0d", e.name, acnt, e.cnt);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    id_src1 = 4'd0; id_src2 = 4'd0; id_src1_vld = 1'b0; id_src2_vld = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    exe_branch = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic chk(input string nm, input bit inst, input logic [4:0] ctl,
                     input bit cc, input int cnt);
    exp_t e;
    e.name = nm; e.inst = inst; e.ctl = ctl; e.chk_cnt = cc; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1;
    chk("rst_d", 0, 5'b00000, 1, 0);
    chk("rst_s", 1, 5'b00000, 1, 0);
    cyc(); rst = 1'b0;
  endtask

  localparam logic [4:0] ST_HZ  = 5'b10100;
  localparam logic [4:0] ST_BR  = 5'b01100;
  localparam logic [4:0] ST_MEM = 5'b10010;
  localparam logic [4:0] ST_ERR = 5'b10011;
  localparam logic [4:0] ST_OFF = 5'b00000;

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_idle", 0, ST_OFF, 1, 0);

    // RAW on src1: producer in EXE, then MEM, then gone
    cyc(); id_src1 = 4'd3; id_src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    chk("raw_exe", 0, FWD ? ST_OFF : ST_HZ, 1, 0);
    cyc(); id_src1 = 4'd3; id_src1_vld = 1'b1; mem_dest = 4'd3; mem_wb_en = 1'b1;
    chk("raw_mem", 0, FWD ? ST_OFF : ST_HZ, 1, FWD ? 0 : 1);
    cyc();
    chk("raw_clear", 0, ST_OFF, 1, FWD ? 0 : 2);

    // branch overrides hazard
    cyc(); id_src1 = 4'd3; id_src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    exe_branch = 1'b1;
    chk("branch_over_hz", 0, ST_BR, 0, 0);

    // memory wait of 5 cycles, branch held from third cycle
    for (int i = 0; i < 5; i++) begin
      cyc(); mem_req = 1'b1; exe_branch = (i >= 2);
      chk($sformatf("mem_wait%0d", i), 0, ST_MEM, 0, 0);
    end
    cyc(); mem_req = 1'b1; mem_ready = 1'b1; exe_branch = 1'b1;
    chk("mem_done_branch", 0, ST_BR, 0, 0);
    cyc();
    chk("mem_run_cnt", 0, ST_OFF, 1, FWD ? 5 : 7);

    // ready in same cycle as request: no stall, no state change
    cyc(); mem_req = 1'b1; mem_ready = 1'b1;
    chk("req_rdy_same", 0, ST_OFF, 0, 0);
    cyc();
    chk("req_rdy_after", 0, ST_OFF, 0, 0);

    // load-use vs ALU producer on src2
    cyc(); id_src2 = 4'd5; id_src2_vld = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1;
    chk("alu_src2", 0, FWD ? ST_OFF : ST_HZ, 0, 0);
    cyc(); id_src2 = 4'd5; id_src2_vld = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1;
    exe_mem_r_en = 1'b1;
    chk("load_src2", 0, ST_HZ, 0, 0);
    cyc(); id_src2 = 4'd5; id_src2_vld = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1;
    chk("load_src2_mem", 0, FWD ? ST_OFF : ST_HZ, 0, 0);
    cyc(); id_src2 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    chk("src2_not_vld", 0, ST_OFF, 0, 0);

    // timeout on TIMEOUT=4 instance, with 2-bit counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(); mem_req = 1'b1;
      chk($sformatf("to_wait%0d", i), 1, ST_MEM, 1, (i > 3) ? 3 : i);
    end
    cyc(); mem_req = 1'b1; mem_ready = 1'b1;
    chk("to_err", 1, ST_ERR, 1, 3);
    cyc();
    chk("to_sticky", 1, ST_ERR, 0, 0);
    cyc(); rst = 1'b1;
    chk("to_rst", 1, ST_OFF, 1, 0);
    cyc(); rst = 1'b0;
    chk("to_cleared", 1, ST_OFF, 1, 0);

    // ready on the timeout cycle wins
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_req = 1'b1;
      chk($sformatf("rw_wait%0d", i), 1, ST_MEM, 0, 0);
    end
    cyc(); mem_req = 1'b1; mem_ready = 1'b1;
    chk("rw_ready_wins", 1, ST_OFF, 1, 3);
    cyc();
    chk("rw_no_err", 1, ST_OFF, 0, 0);

    // async reset mid-wait with request still pending
    do_reset();
    cyc(); mem_req = 1'b1;
    chk("ar_stall", 0, ST_MEM, 0, 0);
    cyc(); mem_req = 1'b1;
    chk("ar_wait", 0, ST_MEM, 0, 0);
    cyc(); mem_req = 1'b1; rst = 1'b1;
    chk("ar_async_d", 0, ST_OFF, 1, 0);
    chk("ar_async_s", 1, ST_OFF, 1, 0);
    cyc(); rst = 1'b0;
    chk("ar_after", 0, ST_OFF, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
